// File: rtl/half_adder_s_if.sv
// half_adder_s_if: operand, enable and result bundle for the half-adder lanes
interface half_adder_s_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  logic [WIDTH-1:0] sout;
  logic [WIDTH-1:0] cout;
  logic [WIDTH-1:0] sout_q;
  logic [WIDTH-1:0] cout_q;
  logic             valid_q;
  modport master (output a, b, en, input sout, cout, sout_q, cout_q, valid_q);
  modport slave  (input a, b, en, output sout, cout, sout_q, cout_q, valid_q);
endinterface

// File: rtl/half_adder_s.sv
// half_adder_s: gate-level half-adder lanes with optional registered result
module half_adder_s #(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  half_adder_s_if.slave     bus
);
  logic [WIDTH-1:0] sum_w, carry_w;
  logic [WIDTH-1:0] sum_q, carry_q, sum_d, carry_d;
  logic             valid_q, valid_d;
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    xor u_xor (sum_w[g], bus.a[g], bus.b[g]);
    and u_and (carry_w[g], bus.a[g], bus.b[g]);
  end
  assign bus.sout    = sum_w;
  assign bus.cout    = carry_w;
  assign bus.sout_q  = sum_q;
  assign bus.cout_q  = carry_q;
  assign bus.valid_q = valid_q;
  // capture the lane results when enabled, otherwise hold
  always_comb begin
    sum_d   = bus.en ? sum_w   : sum_q;
    carry_d = bus.en ? carry_w : carry_q;
    valid_d = bus.en | valid_q;
  end
  // result registers; reset clears them immediately, independent of clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_half_adder_s.sv
// tb_half_adder_s: directed checks of combinational and registered half-adder paths
module tb_half_adder_s;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  half_adder_s_if #(.WIDTH(1)) if1 ();
  half_adder_s_if #(.WIDTH(4)) if4 ();
  half_adder_s #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  half_adder_s #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    if1.a = 1'b0; if1.b = 1'b0; if1.en = 1'b0;
    if4.a = 4'h0; if4.b = 4'h0; if4.en = 1'b0;
    #1;
    check("reset_sout_q", {3'b0, if1.sout_q}, 4'h0);
    check("reset_cout_q", {3'b0, if1.cout_q}, 4'h0);
    check("reset_valid_q", {3'b0, if1.valid_q}, 4'h0);
    check("a0b0_sout", {3'b0, if1.sout}, 4'h0);
    check("a0b0_cout", {3'b0, if1.cout}, 4'h0);
    if1.b = 1'b1; #1;
    check("a0b1_sout_in_rst", {3'b0, if1.sout}, 4'h1);
    check("a0b1_cout_in_rst", {3'b0, if1.cout}, 4'h0);
    if1.b = 1'b0; #1;
    check("a0b0_again_sout", {3'b0, if1.sout}, 4'h0);
    if1.a = 1'b1; #1;
    check("a1b0_sout", {3'b0, if1.sout}, 4'h1);
    check("a1b0_cout", {3'b0, if1.cout}, 4'h0);
    if1.b = 1'b1; #1;
    check("a1b1_sout", {3'b0, if1.sout}, 4'h0);
    check("a1b1_cout", {3'b0, if1.cout}, 4'h1);
    if4.a = 4'b1100; if4.b = 4'b1010; #1;
    check("w4_sout", if4.sout, 4'b0110);
    check("w4_cout", if4.cout, 4'b1000);
    if4.a = 4'b1111; if4.b = 4'b0001; #1;
    check("w4_sout_b", if4.sout, 4'b1110);
    check("w4_cout_b", if4.cout, 4'b0001);
    if1.en = 1'b1; if4.en = 1'b1;
    @(posedge clk); #1;
    check("rst_dominates_cout_q", {3'b0, if1.cout_q}, 4'h0);
    check("rst_dominates_valid_q", {3'b0, if1.valid_q}, 4'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("cap_cout_q", {3'b0, if1.cout_q}, 4'h1);
    check("cap_sout_q", {3'b0, if1.sout_q}, 4'h0);
    check("cap_valid_q", {3'b0, if1.valid_q}, 4'h1);
    check("w4_cap_sout_q", if4.sout_q, 4'b1110);
    check("w4_cap_cout_q", if4.cout_q, 4'b0001);
    if1.en = 1'b0; if4.en = 1'b0;
    if1.a = 1'b0; if1.b = 1'b1; if4.a = 4'b0101; if4.b = 4'b0011;
    repeat (3) @(posedge clk);
    #1;
    check("hold_cout_q", {3'b0, if1.cout_q}, 4'h1);
    check("hold_sout_q", {3'b0, if1.sout_q}, 4'h0);
    check("hold_valid_q", {3'b0, if1.valid_q}, 4'h1);
    check("w4_hold_sout_q", if4.sout_q, 4'b1110);
    if1.en = 1'b1; if4.en = 1'b1;
    @(posedge clk); #1;
    check("recap_sout_q", {3'b0, if1.sout_q}, 4'h1);
    check("recap_cout_q", {3'b0, if1.cout_q}, 4'h0);
    check("w4_recap_sout_q", if4.sout_q, 4'b0110);
    check("w4_recap_cout_q", if4.cout_q, 4'b0001);
    rst = 1'b1; #1;
    check("async_clr_sout_q", {3'b0, if1.sout_q}, 4'h0);
    check("async_clr_valid_q", {3'b0, if1.valid_q}, 4'h0);
    check("w4_async_clr_sout_q", if4.sout_q, 4'h0);
    check("comb_during_rst", {3'b0, if1.sout}, 4'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid_q", {3'b0, if1.valid_q}, 4'h1);
    check("post_rst_sout_q", {3'b0, if1.sout_q}, 4'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
